// File: rtl/status_unit.sv
// CP0 Status register (reg 12): mode, interrupt-enable and exception-level state.
// Latency: updates on the rising edge after a strobe; read_data is combinational from the register.
// Backpressure: none; every strobe is applied on every edge it is held.
module status_unit #(
  parameter logic [31:0] RESET_VALUE = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_p,
  input  logic        r_h,
  input  logic        ei_en,
  input  logic        di_en,
  input  logic        cu0_en,
  input  logic        cp0_unusable,
  input  logic        um_en,
  input  logic        um,
  input  logic        eret,
  input  logic        we_s,
  input  logic        sr,
  input  logic        nmi,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  // Writable bits: CU[31:28], RP, BEV, SR, NMI, IM[15:8], UM, ERL, EXL, IE.
  localparam logic [31:0] WMASK = 32'hF858_FF17;

  localparam int B_CU0 = 28;
  localparam int B_RP  = 27;
  localparam int B_BEV = 22;
  localparam int B_SR  = 20;
  localparam int B_NMI = 19;
  localparam int B_UM  = 4;
  localparam int B_ERL = 2;
  localparam int B_EXL = 1;
  localparam int B_IE  = 0;

  logic [31:0] r_status;
  logic [31:0] w_next;

  assign read_data = r_status;

  // Next-value build: later steps override earlier ones on the same bit.
  always_comb begin
    w_next = r_status;
    if (we_s)   w_next = write_data & WMASK;
    if (cu0_en) w_next[B_CU0] = ~cp0_unusable;
    if (um_en)  w_next[B_UM]  = um;
    if (r_h)    w_next[B_RP]  = 1'b0;
    if (r_p)    w_next[B_RP]  = 1'b1;
    if (ei_en)  w_next[B_IE]  = 1'b1;
    if (di_en)  w_next[B_IE]  = 1'b0;
    // ERET clears only one level, chosen by the pre-edge ERL.
    if (eret) begin
      if (r_status[B_ERL]) w_next[B_ERL] = 1'b0;
      else                 w_next[B_EXL] = 1'b0;
    end
    if (sr) begin
      w_next[B_SR]  = 1'b1;
      w_next[B_BEV] = 1'b1;
      w_next[B_ERL] = 1'b1;
    end
    if (nmi) begin
      w_next[B_NMI] = 1'b1;
      w_next[B_BEV] = 1'b1;
      w_next[B_ERL] = 1'b1;
    end
  end

  // Status register; reset is asynchronous and overrides every strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_status <= RESET_VALUE;
    else     r_status <= w_next;
  end

endmodule

// File: tb/tb_status_unit.sv
module tb_status_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_p, r_h, ei_en, di_en, cu0_en, cp0_unusable, um_en, um;
  logic        eret, we_s, sr, nmi;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_pass   = 0;

  status_unit dut (
    .clk          (clk),
    .rst          (rst),
    .r_p          (r_p),
    .r_h          (r_h),
    .ei_en        (ei_en),
    .di_en        (di_en),
    .cu0_en       (cu0_en),
    .cp0_unusable (cp0_unusable),
    .um_en        (um_en),
    .um           (um),
    .eret         (eret),
    .we_s         (we_s),
    .sr           (sr),
    .nmi          (nmi),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
  endtask

  task automatic idle();
    r_p = 0; r_h = 0; ei_en = 0; di_en = 0; cu0_en = 0; cp0_unusable = 0;
    um_en = 0; um = 0; eret = 0; we_s = 0; sr = 0; nmi = 0; write_data = '0;
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    idle();
    we_s = 1; write_data = v;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("reset_async", read_data, 32'h0040_0004);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("reset_hold", read_data, 32'h0040_0004);
    tick();
    chk("idle_hold", read_data, 32'h0040_0004);

    // Combined write with CU0/UM/RP overrides.
    we_s = 1; write_data = 32'h0000_FF17; cu0_en = 1; cp0_unusable = 0;
    um_en = 1; um = 0; r_p = 1;
    tick();
    chk("combined_write", read_data, 32'h1800_FF07);

    cp0_unusable = 1; um = 1;
    tick();
    chk("override_next", read_data, 32'h0800_FF17);

    we_s = 0; r_p = 0; r_h = 1; di_en = 1;
    tick();
    chk("di", read_data, 32'h0000_FF16);

    di_en = 0; ei_en = 1;
    tick();
    chk("ei", read_data, 32'h0000_FF17);

    idle();
    eret = 1;
    tick();
    chk("eret_erl", read_data, 32'h0000_FF13);
    tick();
    chk("eret_exl", read_data, 32'h0000_FF11);

    idle();
    ei_en = 1; di_en = 1;
    tick();
    chk("ei_di_prio", read_data, 32'h0000_FF10);

    idle();
    r_p = 1; r_h = 1;
    tick();
    chk("rp_rh_prio", read_data, 32'h0800_FF10);

    idle();
    tick();
    chk("hold_no_strobe", read_data, 32'h0800_FF10);

    load(32'h0000_0000);
    chk("write_zero", read_data, 32'h0000_0000);
    nmi = 1;
    tick();
    chk("nmi_entry", read_data, 32'h0048_0004);

    idle();
    sr = 1;
    tick();
    chk("sr_entry", read_data, 32'h0058_0004);

    load(32'h0000_0000);
    sr = 1; nmi = 1;
    tick();
    chk("sr_nmi_both", read_data, 32'h0058_0004);

    load(32'hFFFF_FFFF);
    chk("write_all_ones", read_data, 32'hF858_FF17);

    load(32'h07A7_00E8);
    chk("write_unused_bits", read_data, 32'h0000_0000);

    // ERET with ERL=0 and EXL=0 leaves value unchanged.
    load(32'h0000_0010);
    eret = 1;
    tick();
    chk("eret_nothing", read_data, 32'h0000_0010);

    // Mid-cycle async reset while a write is held.
    idle();
    we_s = 1; write_data = 32'hFFFF_FFFF;
    rst = 1'b1;
    #1;
    chk("reset_mid_cycle", read_data, 32'h0040_0004);
    tick();
    chk("reset_blocks_write", read_data, 32'h0040_0004);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_reset_hold", read_data, 32'h0040_0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
